regfile: RTL

- General-purpose register file with a pending-write scoreboard.
- Sits directly upstream of the ALU; rd_data1/rd_data2 drive the ALU's src1/src2 and replace the standalone input latches.
- Write-back from the ALU result register returns on the write port.
- The scoreboard raises stall when a source register still has an outstanding write.

---
 rtl/regfile.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile.sv
// Register file with registered reads and a pending-write scoreboard.
// Optional same-edge write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_dst,
    output logic                  stall
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;

    logic                  wr_ok;
    logic                  set_ok;
    logic                  hit1;
    logic                  hit2;
    logic                  pend1;
    logic                  pend2;
    logic [DATA_WIDTH-1:0] raw1;
    logic [DATA_WIDTH-1:0] raw2;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (NUM_REGS >= DEPTH) || (32'(a) < 32'(NUM_REGS));
    endfunction

    assign wr_ok  = wr_en && (wr_addr != '0) && in_range(wr_addr);

    // Entries outside the architectural range are never written and read as 0.
    assign raw1 = (rd_addr1 != '0 && in_range(rd_addr1)) ? mem[rd_addr1] : '0;
    assign raw2 = (rd_addr2 != '0 && in_range(rd_addr2)) ? mem[rd_addr2] : '0;

`ifdef REGFILE_BYPASS_EN
    assign hit1 = wr_ok && (wr_addr == rd_addr1);
    assign hit2 = wr_ok && (wr_addr == rd_addr2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign pend1 = busy[rd_addr1] && (rd_addr1 != '0) && !hit1;
    assign pend2 = busy[rd_addr2] && (rd_addr2 != '0) && !hit2;
    assign stall = enable && (pend1 || pend2);

    assign set_ok = issue_valid && !stall && (issue_dst != '0) &&
                    in_range(issue_dst);

    // Set is applied after clear so a newer outstanding write wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[wr_addr] = 1'b0;
        if (set_ok)
            busy_nxt[issue_dst] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            busy     <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else if (enable) begin
            if (wr_ok)
                mem[wr_addr] <= wr_data;
            busy     <= busy_nxt;
            rd_data1 <= hit1 ? wr_data : raw1;
            rd_data2 <= hit2 ? wr_data : raw2;
        end
    end

endmodule
